// File: rtl/coax_rx_frame_decoder.sv
// ============================================================================
// Module   : coax_rx_frame_decoder
// Function : Recovers coax receive frames (quiesce, start violation, sync/data/
//            parity words, zero-sync end) from bit-timer sample strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coax_rx_frame_decoder #(
    parameter int QUIESCE_BITS = 5,
    parameter int DATA_BITS    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 sample,
    input  logic                 synchronized,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_strobe,
    output logic                 parity_error,
    output logic                 active,
    output logic                 frame_end,
    output logic                 error
);

    localparam int ONES_W = $clog2(QUIESCE_BITS + 1);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_VIOL    = 3'd2,
        S_SYNC    = 3'd3,
        S_DATA    = 3'd4,
        S_PARITY  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [ONES_W-1:0]      r_ones;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_strobe;
    logic                   r_parity_error;
    logic                   r_active;
    logic                   r_frame_end;
    logic                   r_error;

    logic w_bit;
    logic w_in_frame;
    logic w_lost;
    logic w_drop;

    assign w_bit      = sample && synchronized;
    assign w_in_frame = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_PARITY);
    // Losing lock inside a frame is reported; losing it during the preamble is not.
    assign w_lost     = !synchronized && w_in_frame;
    assign w_drop     = !synchronized && ((r_state == S_QUIESCE) || (r_state == S_VIOL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ones         <= '0;
            r_idx          <= '0;
            r_shift        <= '0;
            r_data         <= '0;
            r_strobe       <= 1'b0;
            r_parity_error <= 1'b0;
            r_active       <= 1'b0;
            r_frame_end    <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_strobe    <= 1'b0;
            r_frame_end <= 1'b0;
            r_error     <= 1'b0;
            if (w_lost) begin
                r_state  <= S_IDLE;
                r_active <= 1'b0;
                r_error  <= 1'b1;
            end else if (w_drop) begin
                r_state <= S_IDLE;
            end else if (w_bit) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx) begin
                            r_state <= S_QUIESCE;
                            r_ones  <= ONES_W'(1);
                        end
                    end
                    S_QUIESCE: begin
                        if (rx) begin
                            if (r_ones != ONES_W'(QUIESCE_BITS)) begin
                                r_ones <= r_ones + ONES_W'(1);
                            end
                        end else if (r_ones >= ONES_W'(QUIESCE_BITS)) begin
                            r_state <= S_VIOL;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_VIOL: begin
                        if (!rx) begin
                            r_state  <= S_SYNC;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= S_QUIESCE;
                            r_ones  <= ONES_W'(1);
                        end
                    end
                    S_SYNC: begin
                        if (rx) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_active    <= 1'b0;
                            r_frame_end <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_shift[DATA_BITS-2:0], rx};
                        r_idx   <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_data         <= r_shift;
                        r_parity_error <= (^r_shift) ^ rx;
                        r_strobe       <= 1'b1;
                        r_state        <= S_SYNC;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data         = r_data;
    assign data_strobe  = r_strobe;
    assign parity_error = r_parity_error;
    assign active       = r_active;
    assign frame_end    = r_frame_end;
    assign error        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_coax_rx_frame_decoder.sv
// ============================================================================
// Module   : tb_coax_rx_frame_decoder
// Function : Scoreboard bench for coax_rx_frame_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coax_rx_frame_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       sample;
    logic       synchronized;
    logic [9:0] data;
    logic       data_strobe;
    logic       parity_error;
    logic       active;
    logic       frame_end;
    logic       error;

    always #5 clk = ~clk;

    coax_rx_frame_decoder #(.QUIESCE_BITS(5), .DATA_BITS(10)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .sample       (sample),
        .synchronized (synchronized),
        .data         (data),
        .data_strobe  (data_strobe),
        .parity_error (parity_error),
        .active       (active),
        .frame_end    (frame_end),
        .error        (error)
    );

    int          checks   = 0;
    int          failures = 0;
    int          fe_cnt   = 0;
    int          err_cnt  = 0;
    int          exp_fe   = 0;
    int          exp_err  = 0;
    logic [10:0] sb[$];
    logic [10:0] r_exp;
    logic [9:0]  last_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (data_strobe) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    r_exp = sb.pop_front();
                    chk("data", 32'(data), 32'(r_exp[9:0]));
                    chk("parity_error", 32'(parity_error), 32'(r_exp[10]));
                end
            end
            if (frame_end) fe_cnt++;
            if (error)     err_cnt++;
        end
    end

    task automatic bit_ev(input logic b);
        @(negedge clk);
        rx     = b;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bit_unsync(input logic b);
        @(negedge clk);
        rx           = b;
        synchronized = 1'b0;
        sample       = 1'b1;
        @(negedge clk);
        sample       = 1'b0;
        synchronized = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_frame();
        repeat (5) bit_ev(1'b1);
        bit_ev(1'b0);
        bit_ev(1'b0);
    endtask

    task automatic send_word(input logic [9:0] d, input logic p);
        bit_ev(1'b1);
        for (int i = 9; i >= 0; i--) bit_ev(d[i]);
        sb.push_back({(^d) ^ p, d});
        last_data = d;
        bit_ev(p);
    endtask

    task automatic end_frame();
        bit_ev(1'b0);
        exp_fe++;
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_frame_end_cnt"}, 32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_error_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        sample       = 1'b0;
        synchronized = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_strobe", 32'(data_strobe), 32'd0);
        chk("rst_parity", 32'(parity_error), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_frame_end", 32'(frame_end), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean frame, good parity
        repeat (5) bit_ev(1'b1);
        bit_ev(1'b0);
        chk("t1_active_pre", 32'(active), 32'd0);
        bit_ev(1'b0);
        chk("t1_active_post", 32'(active), 32'd1);
        send_word(10'h2A5, 1'b1);
        end_frame();
        frame_checks("t1");

        // Bad parity, frame still ends cleanly; parity flag holds
        start_frame();
        send_word(10'h2A5, 1'b0);
        end_frame();
        frame_checks("t2");
        chk("t2_pe_hold", 32'(parity_error), 32'd1);

        // Short quiesce rejected, then retry after an aborted violation
        repeat (4) bit_ev(1'b1);
        bit_ev(1'b0);
        bit_ev(1'b0);
        chk("t3_short_quiesce", 32'(active), 32'd0);
        repeat (7) bit_ev(1'b1);
        bit_ev(1'b0);
        bit_ev(1'b1);
        repeat (5) bit_ev(1'b1);
        bit_ev(1'b0);
        bit_ev(1'b0);
        chk("t3_accept", 32'(active), 32'd1);
        end_frame();
        frame_checks("t3");

        // Back-to-back words
        start_frame();
        send_word(10'h000, 1'b0);
        send_word(10'h3FF, 1'b0);
        send_word(10'h001, 1'b1);
        end_frame();
        frame_checks("t4");

        // Loss of sync mid-word
        start_frame();
        bit_ev(1'b1);
        repeat (2) begin
            bit_ev(1'b1);
            bit_ev(1'b0);
        end
        @(negedge clk);
        synchronized = 1'b0;
        @(negedge clk);
        synchronized = 1'b1;
        exp_err++;
        repeat (2) @(negedge clk);
        chk("t5_data_held", 32'(data), 32'(last_data));
        frame_checks("t5");
        start_frame();
        send_word(10'h155, 1'b1);
        end_frame();
        frame_checks("t5b");

        // Asynchronous reset mid-word
        start_frame();
        bit_ev(1'b1);
        repeat (3) bit_ev(1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_data", 32'(data), 32'd0);
        chk("t6_rst_active", 32'(active), 32'd0);
        chk("t6_rst_parity", 32'(parity_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Unsynchronized samples in IDLE must not count toward quiesce
        repeat (4) bit_unsync(1'b1);
        bit_ev(1'b1);
        bit_ev(1'b0);
        bit_ev(1'b0);
        chk("t6_unsync_ignored", 32'(active), 32'd0);

        start_frame();
        send_word(10'h0F0, 1'b0);
        end_frame();
        frame_checks("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
